// File: rtl/mem_write_checker.sv
// Store-stream self-check monitor: compares data-memory writes against an ordered
// table of expected (address, data) pairs and latches a pass/fail verdict.
module mem_write_checker #(
   parameter  int unsigned ADDR_W  = 32,
   parameter  int unsigned DATA_W  = 32,
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned TIMEOUT = 100,
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [IDX_W:0]    cfg_count,
   input  logic              cfg_ign_en,
   input  logic [ADDR_W-1:0] cfg_ign_addr,
   input  logic              start,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic [IDX_W:0]    match_cnt,
   output logic [15:0]       write_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] CODE_NONE = 2'd0;
   localparam logic [1:0] CODE_ADDR = 2'd1;
   localparam logic [1:0] CODE_DATA = 2'd2;
   localparam logic [1:0] CODE_TMO  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t            state;
   logic [ADDR_W-1:0] tbl_addr [DEPTH];
   logic [DATA_W-1:0] tbl_data [DEPTH];
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W:0]    count;
   logic              ign_en;
   logic [ADDR_W-1:0] ign_addr;
   logic [TMR_W-1:0]  timer;

   logic              addr_hit;
   logic              data_hit;
   logic              full_hit;
   logic              ign_hit;
   logic              last_match;
   logic              timer_exp;
   logic [IDX_W:0]    match_nxt;
   logic [15:0]       write_nxt;

   // Table is not reset; it is frozen while a run is in progress.
   always_ff @(posedge clk) begin
      if (cfg_we && (state != S_RUN) && (32'(cfg_idx) < DEPTH)) begin
         tbl_addr[cfg_idx] <= cfg_addr;
         tbl_data[cfg_idx] <= cfg_data;
      end
   end

   // Store classification against the current table entry.
   always_comb begin
      addr_hit   = (DataAdr == tbl_addr[ptr]);
      data_hit   = (WriteData == tbl_data[ptr]);
      full_hit   = addr_hit && data_hit;
      ign_hit    = ign_en && (DataAdr == ign_addr);
      match_nxt  = match_cnt + (IDX_W+1)'(1);
      last_match = (match_nxt == count);
      timer_exp  = (timer == TMR_W'(TIMEOUT - 1));
      write_nxt  = (write_cnt == 16'hFFFF) ? write_cnt : write_cnt + 16'd1;
   end

   // Run-control FSM with registered status and diagnostics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= CODE_NONE;
         match_cnt <= '0;
         write_cnt <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         ptr       <= '0;
         count     <= '0;
         ign_en    <= 1'b0;
         ign_addr  <= '0;
         timer     <= '0;
      end else begin
         case (state)
            S_IDLE, S_PASS, S_FAIL: begin
               if (start) begin
                  count     <= cfg_count;
                  ign_en    <= cfg_ign_en;
                  ign_addr  <= cfg_ign_addr;
                  ptr       <= '0;
                  timer     <= '0;
                  match_cnt <= '0;
                  write_cnt <= '0;
                  fail_addr <= '0;
                  fail_data <= '0;
                  fail_code <= CODE_NONE;
                  if (cfg_count == '0) begin
                     state <= S_PASS;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (MemWrite) begin
                  write_cnt <= write_nxt;
               end
               // Terminal store events take priority over the timeout.
               if (MemWrite && full_hit && last_match) begin
                  match_cnt <= match_nxt;
                  state     <= S_PASS;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= 1'b1;
               end else if (MemWrite && !full_hit && !ign_hit) begin
                  fail_code <= addr_hit ? CODE_DATA : CODE_ADDR;
                  fail_addr <= DataAdr;
                  fail_data <= WriteData;
                  state     <= S_FAIL;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  if (MemWrite && full_hit) begin
                     match_cnt <= match_nxt;
                     ptr       <= ptr + IDX_W'(1);
                  end
                  if (timer_exp) begin
                     fail_code <= CODE_TMO;
                     state     <= S_FAIL;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: expected verdicts are queued when a run
// is launched and compared once the checker reports done.
module tb_mem_write_checker;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 100;
   localparam int unsigned IDX_W   = 2;

   logic              clk;
   logic              reset;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic [IDX_W:0]    cfg_count;
   logic              cfg_ign_en;
   logic [ADDR_W-1:0] cfg_ign_addr;
   logic              start;
   logic              MemWrite;
   logic [ADDR_W-1:0] DataAdr;
   logic [DATA_W-1:0] WriteData;
   logic              busy;
   logic              done;
   logic              pass;
   logic [1:0]        fail_code;
   logic [IDX_W:0]    match_cnt;
   logic [15:0]       write_cnt;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;

   typedef struct {
      logic        pass;
      logic [1:0]  code;
      logic [2:0]  match;
      logic [15:0] wc;
      logic [31:0] fa;
      logic [31:0] fd;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   waited;
   int   nbusy;

   mem_write_checker #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_count(cfg_count), .cfg_ign_en(cfg_ign_en), .cfg_ign_addr(cfg_ign_addr),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
      .match_cnt(match_cnt), .write_cnt(write_cnt),
      .fail_addr(fail_addr), .fail_data(fail_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we   = 1'b1;
      cfg_idx  = IDX_W'(idx);
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic start_run(input int cnt, input logic ign, input logic [31:0] ia);
      cfg_count    = (IDX_W+1)'(cnt);
      cfg_ign_en   = ign;
      cfg_ign_addr = ia;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      @(negedge clk);
      MemWrite  = 1'b0;
   endtask

   task automatic expect_result(input logic p, input logic [1:0] c, input int m,
                                input int wc, input logic [31:0] fa, input logic [31:0] fd);
      exp_t e;
      e.pass  = p;
      e.code  = c;
      e.match = 3'(m);
      e.wc    = 16'(wc);
      e.fa    = fa;
      e.fd    = fd;
      exp_q.push_back(e);
   endtask

   task automatic wait_result(input string tag, input int max_wait, output int w);
      exp_t e;
      w = 0;
      while (done !== 1'b1 && w < max_wait) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_pass"}, pass, e.pass);
         chk({tag, "_code"}, fail_code, e.code);
         chk({tag, "_match"}, match_cnt, e.match);
         chk({tag, "_wcnt"}, write_cnt, e.wc);
         chk({tag, "_faddr"}, fail_addr, e.fa);
         chk({tag, "_fdata"}, fail_data, e.fd);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_code"}, fail_code, 0);
      chk({tag, "_match"}, match_cnt, 0);
      chk({tag, "_wcnt"}, write_cnt, 0);
      chk({tag, "_faddr"}, fail_addr, 0);
      chk({tag, "_fdata"}, fail_data, 0);
   endtask

   initial begin
      reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
      cfg_count = '0; cfg_ign_en = 1'b0; cfg_ign_addr = '0; start = 1'b0;
      MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("idle");

      // Scenario 1: ignored store followed by the expected store.
      load(0, 32'd100, 32'd25);
      start_run(1, 1'b1, 32'd96);
      chk("s1_busy_start", busy, 1);
      expect_result(1'b1, 2'd0, 1, 2, 32'd0, 32'd0);
      do_store(32'd96, 32'd7);
      chk("s1_busy_after_ign", busy, 1);
      chk("s1_wcnt_after_ign", write_cnt, 1);
      do_store(32'd100, 32'd25);
      wait_result("s1", 5, waited);
      chk("s1_latency", waited, 0);

      // Scenario 2: right address, wrong data.
      start_run(1, 1'b1, 32'd96);
      expect_result(1'b0, 2'd2, 0, 1, 32'd100, 32'd24);
      do_store(32'd100, 32'd24);
      wait_result("s2", 5, waited);
      chk("s2_latency", waited, 0);

      // Scenario 3: ignore disabled, stray address fails.
      start_run(1, 1'b0, 32'd96);
      expect_result(1'b0, 2'd1, 0, 1, 32'd96, 32'd7);
      do_store(32'd96, 32'd7);
      wait_result("s3", 5, waited);

      // Scenario 4a: timeout with no stores.
      start_run(1, 1'b0, 32'd0);
      expect_result(1'b0, 2'd3, 0, 0, 32'd0, 32'd0);
      nbusy = 0;
      while (busy === 1'b1 && nbusy < 300) begin
         nbusy++;
         @(negedge clk);
      end
      chk("s4_busy_cycles", nbusy, TIMEOUT);
      wait_result("s4_tmo", 0, waited);

      // Scenario 4b: matching store on the final cycle beats the timeout.
      start_run(1, 1'b0, 32'd0);
      expect_result(1'b1, 2'd0, 1, 1, 32'd0, 32'd0);
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("s4b_busy_last", busy, 1);
      do_store(32'd100, 32'd25);
      wait_result("s4b", 0, waited);

      // Scenario 4c: ignored store on the final cycle lets the timeout win.
      start_run(1, 1'b1, 32'd96);
      expect_result(1'b0, 2'd3, 0, 1, 32'd0, 32'd0);
      repeat (TIMEOUT - 1) @(negedge clk);
      do_store(32'd96, 32'd5);
      wait_result("s4c", 0, waited);

      // Scenario 5: four-entry ordered table.
      load(0, 32'd0, 32'd1);
      load(1, 32'd4, 32'd2);
      load(2, 32'd8, 32'd3);
      load(3, 32'd12, 32'd4);
      start_run(4, 1'b0, 32'd0);
      expect_result(1'b1, 2'd0, 4, 4, 32'd0, 32'd0);
      do_store(32'd0, 32'd1);
      do_store(32'd4, 32'd2);
      chk("s5_match_mid", match_cnt, 2);
      do_store(32'd8, 32'd3);
      do_store(32'd12, 32'd4);
      wait_result("s5_inorder", 0, waited);

      start_run(4, 1'b0, 32'd0);
      expect_result(1'b0, 2'd1, 1, 2, 32'd8, 32'd3);
      do_store(32'd0, 32'd1);
      do_store(32'd8, 32'd3);
      wait_result("s5_swap", 0, waited);
      do_store(32'd4, 32'd2);
      chk("s5_hold_wcnt", write_cnt, 2);
      chk("s5_hold_code", fail_code, 1);

      start_run(0, 1'b0, 32'd0);
      expect_result(1'b1, 2'd0, 0, 0, 32'd0, 32'd0);
      wait_result("s5_zero", 0, waited);

      // Scenario 6: cfg_we ignored in RUN, then asynchronous mid-run reset.
      start_run(4, 1'b0, 32'd0);
      do_store(32'd0, 32'd1);
      load(1, 32'd4, 32'd99);
      chk("s6_busy_run", busy, 1);
      chk("s6_match_run", match_cnt, 1);
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("s6_async");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("s6_idle");
      start_run(4, 1'b0, 32'd0);
      expect_result(1'b1, 2'd0, 4, 4, 32'd0, 32'd0);
      do_store(32'd0, 32'd1);
      do_store(32'd4, 32'd2);
      do_store(32'd8, 32'd3);
      do_store(32'd12, 32'd4);
      wait_result("s6_rerun", 0, waited);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesisable, parametrised self-check monitor for the RISC-V core's data-memory write port. It taps `MemWrite`/`DataAdr`/`WriteData` at the `top` boundary and compares each store against a programmable ordered table of expected (address, data) pairs. A tolerated "ignore" address is supported, together with a cycle timeout. Pass/fail status and failure diagnostics are latched, so a bench, FPGA LED or debug register reads the verdict without `$display`.

## Interface

Parameters:
- `ADDR_W`, 32, width of the monitored address.
- `DATA_W`, 32, width of the monitored write data.
- `DEPTH`, 4, number of expected-entry table slots (≥1). `IDX_W = max(1, clog2(DEPTH))`.
- `TIMEOUT`, 100, number of RUN cycles before a timeout failure (≥1).

Ports:
- `clk` in 1: rising-edge clock, the only clock.
- `reset` in 1: asynchronous, active-low; 0 resets immediately.
- `cfg_we` in 1: table write strobe, honoured only in IDLE, PASS or FAIL.
- `cfg_idx` in IDX_W: table slot to write.
- `cfg_addr` in ADDR_W: expected address for the slot.
- `cfg_data` in DATA_W: expected data for the slot.
- `cfg_count` in IDX_W+1: number of table entries to check (0..DEPTH), sampled on `start`.
- `cfg_ign_en` in 1: enables the ignore address, sampled on `start`.
- `cfg_ign_addr` in ADDR_W: tolerated address, sampled on `start`.
- `start` in 1: begins a check run.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in ADDR_W: store address.
- `WriteData` in DATA_W: store data.
- `busy` out 1: high in RUN.
- `done` out 1: high in PASS or FAIL.
- `pass` out 1: high in PASS.
- `fail_code` out 2: 0 none, 1 address mismatch, 2 data mismatch, 3 timeout.
- `match_cnt` out IDX_W+1: number of entries matched so far.
- `write_cnt` out 16: stores seen in RUN, saturating at 16'hFFFF.
- `fail_addr` out ADDR_W: `DataAdr` of the failing store; 0 on timeout.
- `fail_data` out DATA_W: `WriteData` of the failing store; 0 on timeout.

## Operation

- **States:** IDLE, RUN, PASS, FAIL.
- **Reset:** state is IDLE. All outputs are 0, and the pointer, timer and shadow registers are 0. Table contents are undefined after reset and must be reloaded.
- **Table writes:** in any state other than RUN, `cfg_we` writes `{cfg_addr, cfg_data}` to slot `cfg_idx`. An index ≥ DEPTH is dropped. In RUN, `cfg_we` is ignored.
- **`start` in IDLE, PASS or FAIL:**
  - Shadow-registers `cfg_count`, `cfg_ign_en` and `cfg_ign_addr`.
  - Clears the pointer, timer, `match_cnt`, `write_cnt`, `fail_*` and `fail_code`.
  - Enters RUN. If `cfg_count == 0`, it enters PASS instead.
  - `start` in RUN is ignored.
- **Store evaluation in RUN** (`MemWrite` = 1), with `e = table[ptr]`:
  - `DataAdr == e.addr` and `WriteData == e.data`: increment `ptr` and `match_cnt`. If the new `match_cnt == count`, go to PASS.
  - Otherwise, if the ignore address is enabled and `DataAdr == ign_addr`: tolerated, no state change.
  - Otherwise, if `DataAdr == e.addr`: go to FAIL with code 2.
  - Otherwise: go to FAIL with code 1.
  - Entering FAIL on a store latches `fail_addr = DataAdr` and `fail_data = WriteData`.
- **Write counting:** every RUN store, including ignored ones and the failing one, increments `write_cnt`, saturating at 16'hFFFF.
- **Ordering:** matching is strictly in table order. A correct store issued out of order fails with code 1.
- **After PASS/FAIL:** `MemWrite` activity is ignored. All outputs hold until the next `start` or `reset`.
- **Mid-run reset:** asserting `reset` in RUN returns to IDLE with all outputs cleared, asynchronously.

## Timing

- All state and outputs are registered. A store presented before edge N is reflected in the outputs after edge N, so latency is 1 cycle.
- `start` at edge N: `busy` = 1 after edge N.
- **Timer:**
  - The timer counts RUN cycles.
  - At the edge where the timer reaches `TIMEOUT - 1` with no terminal store event, go to FAIL with code 3. `busy` is therefore high for at most TIMEOUT cycles.
- **Same-cycle timeout and store:** store evaluation takes priority. A final matching store gives PASS, and a mismatching store gives code 1 or 2. Only a non-terminal store (a partial match or an ignored store) lets the timeout win.
- Width rules: comparisons are full-width equality. Counters do not wrap.

## Test plan

1. Load slot0 = (100, 25), ignore enabled with address 96, `cfg_count` = 1, then `start`. Drive stores (96, 7) and then (100, 25). Required: PASS one cycle after the second store, `pass` = 1, `match_cnt` = 1, `write_cnt` = 2, `fail_code` = 0.
2. Same setup as scenario 1. Drive store (100, 24). Required: FAIL, `fail_code` = 2, `fail_addr` = 100, `fail_data` = 24.
3. Same setup with ignore disabled. Drive store (96, 7). Required: FAIL, `fail_code` = 1, `fail_addr` = 96.
4. `TIMEOUT` = 100, `cfg_count` = 1, no stores driven. Required: `busy` high for exactly 100 cycles, then FAIL with `fail_code` = 3 and `fail_addr` = 0. Then a repeat with the matching (100, 25) store on the final cycle → PASS.
5. `DEPTH` = 4, table (0, 1), (4, 2), (8, 3), (12, 4):
   - In-order stores → PASS with `match_cnt` = 4.
   - Swapped second and third stores → FAIL with code 1 and `match_cnt` = 1.
   - `cfg_count` = 0 → PASS one cycle after `start`.
6. Pull `reset` low mid-RUN between clock edges. Required: all outputs 0 immediately and state IDLE. A `cfg_we` during RUN must not alter the table; a subsequent run still passes with the originally loaded values.
